// File: rtl/cache_mem_arbiter_pkg.sv
// Shared FSM encoding and grant identifiers for the I/D cache memory arbiter.
// Pure declarations: no latency, no backpressure.
package cache_mem_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick; combinational, zero latency.
// No backpressure: the grant is only consumed while the arbiter sits in IDLE.
module rr_arb2
   import cache_mem_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_gnt
);
   always_comb begin
      o_gnt = GNT_I;
      if (i_req[1] & i_req[0])
         o_gnt = ~i_last;
      else if (i_req[1])
         o_gnt = GNT_D;
   end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I and D line transfers; a line takes >= 2*LINE_WORDS+1 cycles.
// Each beat waits on mem_ready; the waiting requester is held off through stall.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic [31:0]      i_addr,
   output logic             i_valid,
   output logic [31:0]      i_rdata,
   output logic             i_done,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_valid,
   output logic [31:0]      d_rdata,
   output logic             d_done,
   output logic [IDX_W-1:0] beat_idx,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic             stall
);
   localparam int LINE_W = 32 - IDX_W - 2;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_owner;
   logic                r_last;
   logic                r_we;
   logic [LINE_W-1:0]   r_line;
   logic [IDX_W-1:0]    r_beat;
   logic                r_bubble;
   logic                r_vld;
   logic [31:0]         r_rdata;
   logic                w_gnt;
   logic                w_any_req;
   logic                w_beat_acc;
   logic                w_last_beat;
   logic                w_unused_bits;

   assign w_any_req     = i_req | d_req;
   assign w_beat_acc    = mem_req & mem_ready;
   assign w_last_beat   = (r_beat == IDX_W'(LINE_WORDS - 1));
   assign w_unused_bits = ^{i_addr[IDX_W+1:0], d_addr[IDX_W+1:0]};

   rr_arb2 u_arb (
      .i_req  ({d_req, i_req}),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_state_nxt = XFER;
         XFER:    if (w_beat_acc && w_last_beat) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = (r_state == XFER) & ~r_bubble;
      mem_we    = (r_state == XFER) & r_we;
      mem_wdata = ((r_state == XFER) && r_we) ? d_wdata : 32'd0;
      i_done    = (r_state == RESP) & (r_owner == GNT_I);
      d_done    = (r_state == RESP) & (r_owner == GNT_D);
      i_valid   = r_vld & (r_owner == GNT_I);
      d_valid   = r_vld & (r_owner == GNT_D);
      i_rdata   = (r_owner == GNT_I) ? r_rdata : 32'd0;
      d_rdata   = (r_owner == GNT_D) ? r_rdata : 32'd0;
   end

   assign mem_addr = {r_line, r_beat, 2'b00};
   assign beat_idx = r_beat;
   assign stall    = w_any_req & ~(i_done | d_done);

   // The last beat leaves the index parked; RESP is the only place it returns to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner  <= GNT_I;
         r_last   <= GNT_I;
         r_we     <= 1'b0;
         r_line   <= '0;
         r_beat   <= '0;
         r_bubble <= 1'b0;
         r_vld    <= 1'b0;
         r_rdata  <= 32'd0;
      end else begin
         r_vld    <= w_beat_acc;
         r_bubble <= w_beat_acc;
         if (w_beat_acc) begin
            if (!r_we) r_rdata <= mem_rdata;
            if (!w_last_beat) r_beat <= r_beat + 1'b1;
         end
         if (r_state == RESP) r_beat <= '0;
         if (r_state == IDLE && w_any_req) begin
            r_owner <= w_gnt;
            r_last  <= w_gnt;
            r_we    <= (w_gnt == GNT_D) & d_we;
            r_line  <= (w_gnt == GNT_D) ? d_addr[31:IDX_W+2] : i_addr[31:IDX_W+2];
            r_rdata <= 32'd0;
         end
      end
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized scoreboard bench: stimulus pushes expected lines, a negedge monitor pops and checks.
// Memory answers 3 cycles after mem_req with addr ^ 32'hA5A5_0000.
module tb_cache_mem_arbiter;
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wbase;
   } line_t;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_valid;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] wbase;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        d_done;
   logic [1:0]  beat_idx;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall;
   wire  [31:0] d_wdata = wbase + 32'(beat_idx);

   cache_mem_arbiter #(.LINE_WORDS(4), .IDX_W(2)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata), .d_done(d_done),
      .beat_idx(beat_idx), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
   );

   int    vecs = 0;
   int    errs = 0;
   line_t iq[$];
   line_t dq[$];
   bit    oq[$];
   bit    last_srv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int act, input int req);
      vecs++;
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
      logic [1:0] kk;
      kk = k[1:0];
      return {a[31:4], kk, 2'b00};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time %0t exceeded the bound", $time);
      $fatal(1, "watchdog");
   end

   // Memory: ready pulses on the third cycle mem_req has been seen high.
   initial begin
      int cnt;
      cnt = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ready) begin
            mem_ready = 1'b0;
            mem_rdata = 32'd0;
            cnt = 0;
         end else if (mem_req) begin
            cnt++;
            if (cnt == 3) begin
               mem_ready = 1'b1;
               mem_rdata = mem_addr ^ 32'hA5A5_0000;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   int  cyc = 0;
   int  done_cyc = 0;
   int  line_beat = 0;
   int  vcnt = 0;
   bit  cur_owner = 1'b0;
   bit  line_started = 1'b0;
   bit  gap_chk = 1'b0;
   bit  prev_acc = 1'b0;
   bit  prev_req = 1'b0;

   task automatic side_chk(input bit side, input logic vld, input logic done, input logic [31:0] rdata,
                           input logic ovld, input logic odone, input logic [31:0] ordata);
      line_t e;
      string sn;
      sn = side ? "d" : "i";
      if (!(vld || done)) return;
      if ((side ? dq.size() : iq.size()) == 0) begin
         fail_now({sn, "_unexpected_output"}, 0, 1);
         return;
      end
      e = side ? dq[0] : iq[0];
      chk({sn, "_owner"}, 32'(side), 32'(cur_owner));
      if (vld) begin
         if (!e.we) chk({sn, "_rdata"}, rdata, beat_addr(e.addr, vcnt) ^ 32'hA5A5_0000);
         chk({sn, "_other_quiet"}, {ovld, odone, ordata}, 34'd0);
         if (!done) chk("stall_busy", 32'(stall), 32'(i_req | d_req));
         vcnt++;
      end
      if (done) begin
         chk({sn, "_done_with_valid"}, 32'(vld), 32'd1);
         chk({sn, "_beats"}, vcnt, 4);
         chk("stall_at_done", 32'(stall), 32'd0);
         if (side) void'(dq.pop_front());
         else void'(iq.pop_front());
         line_started = 1'b0;
         line_beat = 0;
         vcnt = 0;
         done_cyc = cyc;
         gap_chk = side ? i_req : d_req;
      end
   endtask

   initial begin
      line_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            iq.delete();
            dq.delete();
            oq.delete();
            line_beat = 0;
            vcnt = 0;
            line_started = 1'b0;
            gap_chk = 1'b0;
            prev_acc = 1'b0;
            prev_req = 1'b0;
         end else begin
            if (prev_acc) chk("bubble_after_beat", 32'(mem_req), 32'd0);
            if (mem_req && !prev_req && !line_started) begin
               line_started = 1'b1;
               if (oq.size() == 0) fail_now("grant_unexpected", 0, 1);
               else cur_owner = oq.pop_front();
               if (gap_chk) begin
                  chk("grant_gap", cyc - done_cyc, 2);
                  gap_chk = 1'b0;
               end
            end
            if (mem_req && mem_ready) begin
               if ((cur_owner ? dq.size() : iq.size()) == 0) begin
                  fail_now("mem_beat_unexpected", 0, 1);
               end else begin
                  e = cur_owner ? dq[0] : iq[0];
                  chk("mem_addr", mem_addr, beat_addr(e.addr, line_beat));
                  chk("mem_we", 32'(mem_we), 32'(e.we));
                  if (e.we) chk("mem_wdata", mem_wdata, e.wbase + 32'(line_beat));
               end
               line_beat++;
            end
            prev_acc = mem_req && mem_ready;
            prev_req = mem_req;
            side_chk(1'b0, i_valid, i_done, i_rdata, d_valid, d_done, d_rdata);
            side_chk(1'b1, d_valid, d_done, d_rdata, i_valid, i_done, i_rdata);
         end
      end
   end

   task automatic i_line(input logic [31:0] a);
      line_t e;
      e.addr = a; e.we = 1'b0; e.wbase = 32'd0;
      iq.push_back(e);
      i_addr = a;
      i_req = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #1;
         if (i_done) break;
         if (i_valid) i_addr = $urandom;
      end
      if (!i_done) fail_now("i_done_timeout", 0, 1);
      i_req = 1'b0;
   endtask

   task automatic d_line(input logic [31:0] a, input logic we, input logic [31:0] wb);
      line_t e;
      e.addr = a; e.we = we; e.wbase = wb;
      dq.push_back(e);
      d_addr = a;
      d_we = we;
      wbase = wb;
      d_req = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #1;
         if (d_done) break;
         if (d_valid) begin
            d_addr = $urandom;
            d_we = 1'($urandom);
         end
      end
      if (!d_done) fail_now("d_done_timeout", 0, 1);
      d_req = 1'b0;
   endtask

   // Reference order: with both sides asking, the side not served last goes first.
   task automatic round(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                        input logic dwe, input logic [31:0] wb);
      bit f;
      if (ri && rd) begin
         f = ~last_srv;
         oq.push_back(f);
         oq.push_back(~f);
         last_srv = ~f;
      end else if (ri) begin
         oq.push_back(1'b0);
         last_srv = 1'b0;
      end else if (rd) begin
         oq.push_back(1'b1);
         last_srv = 1'b1;
      end
      fork
         begin if (ri) i_line(ia); end
         begin if (rd) d_line(da, dwe, wb); end
      join
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_beat(input logic [1:0] b);
      int n;
      n = 0;
      while (beat_idx != b && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) fail_now("beat_wait_timeout", n, 100);
   endtask

   initial begin
      line_t e;
      bit    f;
      rst = 1'b1;
      i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; wbase = 32'd0;
      last_srv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_outputs", {mem_req, mem_we, i_valid, i_done, d_valid, d_done, stall, beat_idx},
          10'd0);
      chk("reset_data", mem_addr | mem_wdata | i_rdata | d_rdata, 32'd0);
      @(posedge clk);
      #1;

      round(1'b1, 1'b0, 32'h0000_0104, 32'd0, 1'b0, 32'd0);
      round(1'b1, 1'b1, 32'h0000_3010, 32'h0000_5020, 1'b0, 32'd0);

      // Both sides re-raise immediately after their done, two lines each.
      f = ~last_srv;
      for (int k = 0; k < 4; k++) oq.push_back(f ^ k[0]);
      last_srv = ~f;
      fork
         begin
            i_line(32'h0000_7000);
            @(posedge clk); #1;
            i_line(32'h0000_7040);
         end
         begin
            d_line(32'h0000_9000, 1'b0, 32'd0);
            @(posedge clk); #1;
            d_line(32'h0000_9040, 1'b1, 32'h1234_0000);
         end
      join
      repeat (2) @(posedge clk);
      #1;

      round(1'b0, 1'b1, 32'd0, 32'h0000_2000, 1'b1, 32'hC0DE_0000);

      for (int r = 0; r < 12; r++) begin
         int sel;
         sel = $urandom_range(1, 3);
         round(sel[0], sel[1], $urandom, $urandom, 1'($urandom), $urandom);
      end

      // Reset in the middle of an I fill: the partial line is abandoned.
      oq.push_back(1'b0);
      last_srv = 1'b0;
      e.addr = $urandom; e.we = 1'b0; e.wbase = 32'd0;
      iq.push_back(e);
      i_addr = e.addr;
      i_req = 1'b1;
      wait_beat(2'd2);
      rst = 1'b1;
      i_req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_outputs", {mem_req, i_valid, i_done, beat_idx}, 5'd0);
      last_srv = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_no_done_after", 32'(i_done), 32'd0);
      round(1'b1, 1'b0, e.addr, 32'd0, 1'b0, 32'd0);

      // I drops its request mid-line; the line still completes.
      oq.push_back(1'b0);
      last_srv = 1'b0;
      e.addr = 32'h0000_0A00; e.we = 1'b0; e.wbase = 32'd0;
      iq.push_back(e);
      i_addr = e.addr;
      i_req = 1'b1;
      wait_beat(2'd1);
      i_req = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (i_done) break;
         @(posedge clk);
         #1;
      end
      chk("drop_done_seen", 32'(i_done), 32'd1);
      chk("drop_stall_at_done", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      chk("drop_after", {stall, mem_req}, 2'd0);

      repeat (10) @(posedge clk);
      #1;
      chk("leftover_expectations", iq.size() + dq.size() + oq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
